// File: rtl/cfg_reg_pkg.sv
// Shared constants for the configuration register bank: register indices,
// command/ctrl codes and the write-lock state encoding.
package cfg_reg_pkg;

   localparam int IDX_CTRL = 0;
   localparam int IDX_CMD  = 1;

   localparam logic [15:0] CMD_RST    = 16'h0055;
   localparam logic [15:0] CMD_CYC    = 16'h0060;
   localparam logic [15:0] CMD_LOCK   = 16'h00A5;
   localparam logic [15:0] KEY1       = 16'h5A5A;
   localparam logic [15:0] KEY2       = 16'hA5A5;
   localparam logic [15:0] CMD_COMMIT = 16'h00C0;

   localparam logic [15:0] CTRL_TRG_ON = 16'h0001;
   localparam logic [15:0] CTRL_TRG_OFF = 16'h0000;
   localparam logic [15:0] CTRL_DT_ON  = 16'h0002;
   localparam logic [15:0] CTRL_DT_OFF = 16'h0003;

   typedef enum logic [1:0] {
      LK_UNLOCKED = 2'd0,
      LK_LOCKED   = 2'd1,
      LK_ARMED    = 2'd2
   } lock_state_t;

endpackage

// File: rtl/cfg_pulse_gen.sv
// Fixed-length pulse generator: a trigger while idle produces a pulse of
// exactly PULSE_LEN cycles starting the next cycle; triggers while busy are ignored.
module cfg_pulse_gen #(
   parameter int PULSE_LEN = 50
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic trig_i,
   output logic pulse_o
);

   localparam int CW = $clog2(PULSE_LEN + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
      else if (trig_i)
         cnt_d = CW'(PULSE_LEN);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign pulse_o = (cnt_q != '0);

endmodule

// File: rtl/cfg_reg_bank.sv
// Configuration register bank with readback, key-protected write lock, command
// pulses and saturating counters. Define CFG_SHADOW_EN for a committed shadow bank.
module cfg_reg_bank
   import cfg_reg_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 8,
   parameter int NUM_REGS  = 20,
   parameter int BASE_ADDR = 8'h02,
   parameter int PULSE_LEN = 50,
   parameter int CNT_W     = 16,
   parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS = '0
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic                         wr_in,
   input  logic [ADDR_W-1:0]            wr_addr_in,
   input  logic [DATA_W-1:0]            data_in,
   input  logic                         rd_in,
   input  logic [ADDR_W-1:0]            rd_addr_in,
   output logic [DATA_W-1:0]            rd_data_out,
   output logic                         rd_valid_out,
   output logic [NUM_REGS*DATA_W-1:0]   regs_out,
   output logic                         trg_enb_out,
   output logic                         data_trans_enb_out,
   output logic                         cmd_rst_out,
   output logic                         cycled_trg_bgn_out,
   output logic                         locked_out,
   output logic [CNT_W-1:0]             config_received_out,
   output logic [CNT_W-1:0]             addr_err_cnt_out
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam logic [ADDR_W:0]   ADDR_LO = (ADDR_W+1)'(BASE_ADDR);
   localparam logic [ADDR_W:0]   ADDR_HI = (ADDR_W+1)'(BASE_ADDR + NUM_REGS);
   localparam logic [IDX_W-1:0]  I_CTRL  = IDX_W'(IDX_CTRL);
   localparam logic [IDX_W-1:0]  I_CMD   = IDX_W'(IDX_CMD);
   localparam logic [IDX_W-1:0]  I_GEN   = IDX_W'(2);
   localparam logic [DATA_W-1:0] D_RST   = DATA_W'(CMD_RST);
   localparam logic [DATA_W-1:0] D_CYC   = DATA_W'(CMD_CYC);
   localparam logic [DATA_W-1:0] D_LOCK  = DATA_W'(CMD_LOCK);
   localparam logic [DATA_W-1:0] D_KEY1  = DATA_W'(KEY1);
   localparam logic [DATA_W-1:0] D_KEY2  = DATA_W'(KEY2);
   localparam logic [DATA_W-1:0] D_TRG_ON  = DATA_W'(CTRL_TRG_ON);
   localparam logic [DATA_W-1:0] D_TRG_OFF = DATA_W'(CTRL_TRG_OFF);
   localparam logic [DATA_W-1:0] D_DT_ON   = DATA_W'(CTRL_DT_ON);
   localparam logic [DATA_W-1:0] D_DT_OFF  = DATA_W'(CTRL_DT_OFF);

   logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d, rd_word;
   logic              rd_valid_q, wr_prev_q;
   logic              trg_enb_q, trg_enb_d, dte_q, dte_d;
   logic [CNT_W-1:0]  cfg_cnt_q, cfg_cnt_d, err_cnt_q, err_cnt_d;
   lock_state_t       lock_q, lock_d;
   logic [IDX_W-1:0]  wr_sel, rd_sel;
   logic wr_inr, rd_inr, wr_rise, wr_acc, wr_drop, ctrl_wr, cmd_wr;
`ifdef CFG_SHADOW_EN
   localparam logic [DATA_W-1:0] D_COMMIT = DATA_W'(CMD_COMMIT);
   logic [NUM_REGS-1:0][DATA_W-1:0] shadow_q, shadow_d;
`endif

   assign wr_sel  = IDX_W'(wr_addr_in - ADDR_W'(BASE_ADDR));
   assign rd_sel  = IDX_W'(rd_addr_in - ADDR_W'(BASE_ADDR));
   assign wr_inr  = ({1'b0, wr_addr_in} >= ADDR_LO) && ({1'b0, wr_addr_in} < ADDR_HI);
   assign rd_inr  = ({1'b0, rd_addr_in} >= ADDR_LO) && ({1'b0, rd_addr_in} < ADDR_HI);
   assign wr_rise = wr_in && !wr_prev_q;
   // ctrl and cmd stay writable while locked so the unlock keys can get through
   assign wr_drop = wr_in && wr_inr && (lock_q != LK_UNLOCKED) && (wr_sel >= I_GEN);
   assign wr_acc  = wr_in && wr_inr && !wr_drop;
   assign ctrl_wr = wr_acc && (wr_sel == I_CTRL);
   assign cmd_wr  = wr_acc && (wr_sel == I_CMD);

   always_comb begin
      regs_d = regs_q;
`ifdef CFG_SHADOW_EN
      shadow_d = shadow_q;
      if (wr_acc && wr_sel >= I_GEN) shadow_d[wr_sel] = data_in;
      else if (wr_acc)               regs_d[wr_sel]   = data_in;
      if (cmd_wr && data_in == D_COMMIT)
         regs_d[NUM_REGS-1:2] = shadow_q[NUM_REGS-1:2];
`else
      if (wr_acc) regs_d[wr_sel] = data_in;
`endif
   end

   always_comb begin
      trg_enb_d = trg_enb_q;
      dte_d     = dte_q;
      if (ctrl_wr) begin
         case (data_in)
            D_TRG_ON:  trg_enb_d = 1'b1;
            D_TRG_OFF: trg_enb_d = 1'b0;
            D_DT_ON:   dte_d     = 1'b1;
            D_DT_OFF:  dte_d     = 1'b0;
            default: ;
         endcase
      end
      cfg_cnt_d = cfg_cnt_q;
      if (wr_rise && wr_acc && cfg_cnt_q != '1) cfg_cnt_d = cfg_cnt_q + CNT_W'(1);
      err_cnt_d = err_cnt_q;
      if (wr_rise && (!wr_inr || wr_drop) && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
   end

   // readback samples the registered value, so a same-cycle write is not visible
   always_comb begin
      rd_word = regs_q[rd_sel];
`ifdef CFG_SHADOW_EN
      if (rd_sel >= I_GEN) rd_word = shadow_q[rd_sel];
`endif
      rd_data_d = rd_data_q;
      if (rd_in) rd_data_d = rd_inr ? rd_word : '0;
   end

   always_comb begin
      lock_d = lock_q;
      if (wr_rise && wr_inr) begin
         case (lock_q)
            LK_UNLOCKED: if (cmd_wr && data_in == D_LOCK) lock_d = LK_LOCKED;
            LK_LOCKED:   if (cmd_wr && data_in == D_KEY1) lock_d = LK_ARMED;
            LK_ARMED:    lock_d = (cmd_wr && data_in == D_KEY2) ? LK_UNLOCKED : LK_LOCKED;
            default:     lock_d = LK_UNLOCKED;
         endcase
      end
   end

   always_comb locked_out = (lock_q != LK_UNLOCKED);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) lock_q <= LK_UNLOCKED;
      else        lock_q <= lock_d;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         regs_q     <= RST_VALS;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         wr_prev_q  <= 1'b0;
         trg_enb_q  <= 1'b0;
         dte_q      <= 1'b0;
         cfg_cnt_q  <= '0;
         err_cnt_q  <= '0;
      end else begin
         regs_q     <= regs_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_in;
         wr_prev_q  <= wr_in;
         trg_enb_q  <= trg_enb_d;
         dte_q      <= dte_d;
         cfg_cnt_q  <= cfg_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

`ifdef CFG_SHADOW_EN
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) shadow_q <= RST_VALS;
      else        shadow_q <= shadow_d;
   end
`endif

   cfg_pulse_gen #(.PULSE_LEN(PULSE_LEN)) u_rst_pulse (
      .clk_i(clk_in), .rst_i(rst_in),
      .trig_i(cmd_wr && data_in == D_RST), .pulse_o(cmd_rst_out)
   );

   cfg_pulse_gen #(.PULSE_LEN(PULSE_LEN)) u_cyc_pulse (
      .clk_i(clk_in), .rst_i(rst_in),
      .trig_i(cmd_wr && data_in == D_CYC), .pulse_o(cycled_trg_bgn_out)
   );

   assign regs_out            = regs_q;
   assign rd_data_out         = rd_data_q;
   assign rd_valid_out        = rd_valid_q;
   assign trg_enb_out         = trg_enb_q;
   assign data_trans_enb_out  = dte_q;
   assign config_received_out = cfg_cnt_q;
   assign addr_err_cnt_out    = err_cnt_q;

endmodule
